// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight; operands and results are registered around the ALU.
//
// state | meaning
// IDLE  | waiting for a request, grant combinational from valids
// EXEC  | operands on the ALU, result captured at the end of this cycle
// RESP  | response valid to owner, held until owner's ready
module alu_share_arbiter #(
    parameter int WIDTH    = 32,
    parameter int CTRL_W   = 4,
    parameter int MAX_CTRL = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [WIDTH-1:0]  i_req0_a,
    input  logic [WIDTH-1:0]  i_req0_b,
    input  logic [CTRL_W-1:0] i_req0_ctrl,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [WIDTH-1:0]  i_req1_a,
    input  logic [WIDTH-1:0]  i_req1_b,
    input  logic [CTRL_W-1:0] i_req1_ctrl,
    output logic              o_rsp0_valid,
    input  logic              i_rsp0_ready,
    output logic [WIDTH-1:0]  o_rsp0_result,
    output logic              o_rsp0_of,
    output logic              o_rsp0_err,
    output logic              o_rsp1_valid,
    input  logic              i_rsp1_ready,
    output logic [WIDTH-1:0]  o_rsp1_result,
    output logic              o_rsp1_of,
    output logic              o_rsp1_err,
    output logic [WIDTH-1:0]  o_alu_a,
    output logic [WIDTH-1:0]  o_alu_b,
    output logic [CTRL_W-1:0] o_alu_ctrl,
    input  logic [WIDTH-1:0]  i_alu_result,
    input  logic              i_alu_of,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [CTRL_W-1:0] MAX_CODE = CTRL_W'(MAX_CTRL);

    state_t             state;
    logic               last;
    logic               owner;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [WIDTH-1:0]   res_q;
    logic               of_q;
    logic               err_q;
    logic               rsp0_v;
    logic               rsp1_v;
    logic               grant0;
    logic               grant1;
    logic               op_err;
    logic               owner_ready;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (i_req0_valid && i_req1_valid) begin
                grant0 = last;
                grant1 = !last;
            end else begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid;
            end
        end
    end

    assign op_err      = (ctrl_q > MAX_CODE);
    assign owner_ready = owner ? i_rsp1_ready : i_rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last   <= 1'b1;
            owner  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= '0;
            res_q  <= '0;
            of_q   <= 1'b0;
            err_q  <= 1'b0;
            rsp0_v <= 1'b0;
            rsp1_v <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q    <= grant1 ? i_req1_a    : i_req0_a;
                        b_q    <= grant1 ? i_req1_b    : i_req0_b;
                        ctrl_q <= grant1 ? i_req1_ctrl : i_req0_ctrl;
                        owner  <= grant1;
                        last   <= grant1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_q  <= op_err ? '0 : i_alu_result;
                    of_q   <= op_err ? 1'b0 : i_alu_of;
                    err_q  <= op_err;
                    rsp0_v <= !owner;
                    rsp1_v <= owner;
                    state  <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        rsp0_v <= 1'b0;
                        rsp1_v <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req0_ready  = grant0;
    assign o_req1_ready  = grant1;
    assign o_rsp0_valid  = rsp0_v;
    assign o_rsp1_valid  = rsp1_v;
    assign o_rsp0_result = res_q;
    assign o_rsp1_result = res_q;
    assign o_rsp0_of     = of_q;
    assign o_rsp1_of     = of_q;
    assign o_rsp0_err    = err_q;
    assign o_rsp1_err    = err_q;
    assign o_alu_a       = a_q;
    assign o_alu_b       = b_q;
    assign o_alu_ctrl    = ctrl_q;
    assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU on the shared port.
// Expected responses are queued at accept time and compared when consumed.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd11;

    typedef struct packed {
        logic [31:0] r;
        logic        of;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [3:0]  i_req0_ctrl, i_req1_ctrl;
    logic        o_rsp0_valid, o_rsp1_valid;
    logic        i_rsp0_ready, i_rsp1_ready;
    logic [31:0] o_rsp0_result, o_rsp1_result;
    logic        o_rsp0_of, o_rsp1_of, o_rsp0_err, o_rsp1_err;
    logic [31:0] o_alu_a, o_alu_b, i_alu_result;
    logic [3:0]  o_alu_ctrl;
    logic        i_alu_of;
    logic        o_busy;
    logic [32:0] alu_out;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_ctrl(i_req0_ctrl),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_ctrl(i_req1_ctrl),
        .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
        .o_rsp0_result(o_rsp0_result), .o_rsp0_of(o_rsp0_of), .o_rsp0_err(o_rsp0_err),
        .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
        .o_rsp1_result(o_rsp1_result), .o_rsp1_of(o_rsp1_of), .o_rsp1_err(o_rsp1_err),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
        .i_alu_result(i_alu_result), .i_alu_of(i_alu_of),
        .o_busy(o_busy)
    );

    // Behavioural ALU; illegal codes return junk so the arbiter's forcing is visible.
    function automatic logic [32:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a - b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_SLT:  return 33'($signed(a) < $signed(b));
            4'd6:    return 33'(a < b);
            4'd7:    return {1'b0, a << b[4:0]};
            4'd8:    return {1'b0, a >> b[4:0]};
            4'd9:    return {1'b0, ~(a | b)};
            4'd10:   return {1'b0, b};
            OP_SRA:  return {1'b0, 32'($signed(a) >>> b[4:0])};
            default: return {1'b1, a ^ b ^ 32'hDEAD_BEEF};
        endcase
    endfunction

    function automatic exp_t expect_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        if (c > 4'd11) return '{r: 32'h0, of: 1'b0, err: 1'b1};
        r = alu_f(c, a, b);
        return '{r: r[31:0], of: r[32], err: 1'b0};
    endfunction

    assign alu_out      = alu_f(o_alu_ctrl, o_alu_a, o_alu_b);
    assign i_alu_result = alu_out[31:0];
    assign i_alu_of     = alu_out[32];

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            n_cmp++;
            if (o_req0_ready && o_req1_ready) begin
                n_fail++;
                $display("FAIL ready_exclusive: both ready high, required at most one");
            end
            if (i_req0_valid && o_req0_ready) q0.push_back(expect_f(i_req0_ctrl, i_req0_a, i_req0_b));
            if (i_req1_valid && o_req1_ready) q1.push_back(expect_f(i_req1_ctrl, i_req1_a, i_req1_b));
            if (o_rsp0_valid && i_rsp0_ready) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp0_unexpected: response with empty queue, result=%h", o_rsp0_result);
                end else begin
                    e = q0.pop_front();
                    if ({o_rsp0_result, o_rsp0_of, o_rsp0_err} !== {e.r, e.of, e.err}) begin
                        n_fail++;
                        $display("FAIL rsp0_data: got r=%h of=%b err=%b, required r=%h of=%b err=%b",
                                 o_rsp0_result, o_rsp0_of, o_rsp0_err, e.r, e.of, e.err);
                    end
                end
            end
            if (o_rsp1_valid && i_rsp1_ready) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp1_unexpected: response with empty queue, result=%h", o_rsp1_result);
                end else begin
                    e = q1.pop_front();
                    if ({o_rsp1_result, o_rsp1_of, o_rsp1_err} !== {e.r, e.of, e.err}) begin
                        n_fail++;
                        $display("FAIL rsp1_data: got r=%h of=%b err=%b, required r=%h of=%b err=%b",
                                 o_rsp1_result, o_rsp1_of, o_rsp1_err, e.r, e.of, e.err);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send(input bit r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        int  n = 0;
        bit  acc = 1'b0;
        if (r) begin
            i_req1_a = a; i_req1_b = b; i_req1_ctrl = c; i_req1_valid = 1'b1;
        end else begin
            i_req0_a = a; i_req0_b = b; i_req0_ctrl = c; i_req0_valid = 1'b1;
        end
        while (!acc && n < 50) begin
            @(negedge clk);
            n++;
            acc = r ? o_req1_ready : o_req0_ready;
        end
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_timeout: req%0d not accepted in %0d cycles", r, n);
        end
        @(posedge clk); #1;
        if (r) i_req1_valid = 1'b0; else i_req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit r);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(r ? o_rsp1_valid : o_rsp0_valid) && n < 50);
        n_cmp++;
        if (!(r ? o_rsp1_valid : o_rsp0_valid)) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp%0d valid not seen in %0d cycles", r, n);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((o_busy || q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (o_busy || q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b q0=%0d q1=%0d, required idle and empty",
                     o_busy, q0.size(), q1.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/rdy0/rdy1/v0/v1=%b, required 00000",
                     {o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid});
        end
        n_cmp++;
        if ({o_rsp0_result, o_rsp0_of, o_rsp0_err, o_alu_a, o_alu_b, o_alu_ctrl} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: res=%h of=%b err=%b alu_a=%h alu_b=%h ctrl=%h, required all 0",
                     o_rsp0_result, o_rsp0_of, o_rsp0_err, o_alu_a, o_alu_b, o_alu_ctrl);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        i_req0_a = 32'h5; i_req0_b = 32'h3; i_req0_ctrl = OP_ADD; i_req0_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: rdy0=%b rdy1=%b, required 1 0", o_req0_ready, o_req1_ready);
        end
        @(posedge clk); #1;
        i_req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_rsp0_valid !== 1'b0 || o_busy !== 1'b1 || o_req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_exec: v0=%b busy=%b rdy1=%b, required 0 1 0", o_rsp0_valid, o_busy, o_req1_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (o_rsp0_valid !== 1'b1 || o_rsp0_result !== 32'h8 || o_rsp0_of !== 1'b0 ||
            o_rsp0_err !== 1'b0 || o_req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: v0=%b res=%h of=%b err=%b rdy1=%b, required 1 8 0 0 0",
                     o_rsp0_valid, o_rsp0_result, o_rsp0_of, o_rsp0_err, o_req1_ready);
        end
        wait_drain();
    endtask

    task automatic test_overflow();
        send(1'b1, 32'hFFFF_FFFF, 32'h1, OP_ADD);
        wait_rsp(1'b1);
        n_cmp++;
        if (o_rsp1_result !== 32'h0 || o_rsp1_of !== 1'b1 || o_rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow: res=%h of=%b v0=%b, required 0 1 0", o_rsp1_result, o_rsp1_of, o_rsp0_valid);
        end
        wait_drain();
    endtask

    task automatic test_contention();
        int who[4];
        int when[4];
        int got = 0;
        int n = 0;
        apply_reset();
        i_req0_a = 32'd10; i_req0_b = 32'd3; i_req0_ctrl = OP_SUB;
        i_req1_a = 32'hFFFF_FFFF; i_req1_b = 32'd1; i_req1_ctrl = OP_SLT;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        while (got < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (o_req0_ready) begin who[got] = 0; when[got] = n; got++; end
            else if (o_req1_ready) begin who[got] = 1; when[got] = n; got++; end
        end
        @(posedge clk); #1;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        n_cmp++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL contention_count: %0d grants, required 4", got);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (who[i] != (i % 2)) begin
                    n_fail++;
                    $display("FAIL contention_order: grant %0d to req%0d, required req%0d", i, who[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (when[i] - when[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL contention_spacing: gap %0d cycles, required 3", when[i] - when[i-1]);
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        i_rsp0_ready = 1'b0;
        send(1'b0, 32'h0000_F0F0, 32'h0000_FF00, OP_AND);
        i_req1_a = 32'd1; i_req1_b = 32'd2; i_req1_ctrl = OP_ADD; i_req1_valid = 1'b1;
        wait_rsp(1'b0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (o_rsp0_valid !== 1'b1 || o_rsp0_result !== 32'h0000_F000 || o_rsp0_of !== 1'b0 ||
                o_busy !== 1'b1 || o_req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: v0=%b res=%h of=%b busy=%b rdy1=%b, required 1 0000f000 0 1 0",
                         o_rsp0_valid, o_rsp0_result, o_rsp0_of, o_busy, o_req1_ready);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_rsp0_valid !== 1'b0 || o_req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: busy=%b v0=%b rdy1=%b, required 0 0 1",
                     o_busy, o_rsp0_valid, o_req1_ready);
        end
        @(posedge clk); #1;
        i_req1_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_illegal();
        send(1'b0, 32'h1234, 32'h1, 4'hF);
        wait_rsp(1'b0);
        n_cmp++;
        if (o_rsp0_result !== 32'h0 || o_rsp0_of !== 1'b0 || o_rsp0_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_op: res=%h of=%b err=%b, required 0 0 1", o_rsp0_result, o_rsp0_of, o_rsp0_err);
        end
        wait_drain();
        send(1'b1, 32'h8000_0000, 32'd4, OP_SRA);
        wait_rsp(1'b1);
        n_cmp++;
        if (o_rsp1_result !== 32'hF800_0000 || o_rsp1_err !== 1'b0) begin
            n_fail++;
            $display("FAIL legal_after_illegal: res=%h err=%b, required f8000000 0", o_rsp1_result, o_rsp1_err);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_resp();
        int n = 0;
        i_rsp0_ready = 1'b0;
        send(1'b0, 32'h5, 32'h3, OP_ADD);
        wait_rsp(1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_rsp0_valid, o_rsp0_result, o_rsp0_of, o_rsp0_err, o_busy, o_alu_a, o_alu_b, o_alu_ctrl} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_resp: v0=%b res=%h of=%b err=%b busy=%b alu_a=%h alu_b=%h, required all 0",
                     o_rsp0_valid, o_rsp0_result, o_rsp0_of, o_rsp0_err, o_busy, o_alu_a, o_alu_b);
        end
        q0.delete();
        q1.delete();
        i_rsp0_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o_rsp0_valid !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_rsp: v0=%b busy=%b after reset, required 0 0", o_rsp0_valid, o_busy);
            end
        end
        @(posedge clk); #1;
        i_req0_a = 32'h00F0; i_req0_b = 32'h0F00; i_req0_ctrl = OP_OR;  i_req0_valid = 1'b1;
        i_req1_a = 32'h00FF; i_req1_b = 32'h0F0F; i_req1_ctrl = OP_XOR; i_req1_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: rdy0=%b rdy1=%b, required 1 0", o_req0_ready, o_req1_ready);
        end
        @(posedge clk); #1;
        i_req0_valid = 1'b0;
        while (!o_req1_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        i_req1_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_req0_a = '0; i_req0_b = '0; i_req0_ctrl = '0;
        i_req1_a = '0; i_req1_b = '0; i_req1_ctrl = '0;
        i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
        test_reset();
        test_single();
        test_overflow();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
